mis_shaping_lf_nth: RTL and testbench



---
 rtl/mis_lf_pkg.sv | 23 ++
 rtl/mis_min_tree.sv | 24 ++
 rtl/mis_shaping_lf_nth.sv | 124 ++++++++++++
 tb/tb_mis_shaping_lf_nth.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/mis_lf_pkg.sv
// Shared constants, helpers and types for the mismatch-shaping loop filter.
`timescale 1ns/1ps
package mis_lf_pkg;
    localparam int MAX_ORDER_LIMIT = 4;

    // One bit per possible stage, e.g. per-stage saturation events.
    typedef logic [MAX_ORDER_LIMIT-1:0] stage_vec_t;

    // Internal signed width: room for sum of two clamped stages minus one.
    function automatic int sw_int(input int sw);
        return sw + 3;
    endfunction

    function automatic logic [2:0] clamp_order(input logic [2:0] order_sel, input int max_order);
        logic [2:0] o;
        o = order_sel;
        if (o == 3'd0)
            o = 3'd1;
        else if (int'(o) > max_order)
            o = 3'(max_order);
        return o;
    endfunction
endpackage

// File: rtl/mis_min_tree.sv
// Combinational balanced signed-minimum over a flat bus of N W-bit words.
`timescale 1ns/1ps
module mis_min_tree #(
    parameter int N = 4,
    parameter int W = 8
) (
    input  logic [N*W-1:0]        din,
    output logic signed [W-1:0]   dmin
);
    localparam int NP = 1 << $clog2(N);

    // Heap layout: leaves at NP-1..2*NP-2, root at 0. Spare leaves repeat real words.
    logic signed [W-1:0] node [2*NP-1];

    always_comb begin
        for (int j = 0; j < 2*NP-1; j++)
            node[j] = '0;
        for (int j = 0; j < NP; j++)
            node[NP-1+j] = din[(j % N)*W +: W];
        for (int j = NP-2; j >= 0; j--)
            node[j] = (node[2*j+1] < node[2*j+2]) ? node[2*j+1] : node[2*j+2];
        dmin = node[0];
    end
endmodule

// File: rtl/mis_shaping_lf_nth.sv
// Parametrised mismatch-shaping loop filter with run-time order and saturating stages.
`timescale 1ns/1ps
module mis_shaping_lf_nth
    import mis_lf_pkg::*;
#(
    parameter int N_ELEM    = 18,
    parameter int MAX_ORDER = 2,
    parameter int SW        = 7
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clk_en,
    input  logic [2:0]               order_sel,
    input  logic                     sat_clr,
    input  logic [N_ELEM-1:0]        SV,
    output logic [N_ELEM-1:0]        SD,
    output logic [N_ELEM*(SW+1)-1:0] SFM,
    output logic                     sat_flag
);
    localparam int IW = sw_int(SW);
    localparam int OW = SW + 1;
    localparam logic signed [IW-1:0] SAT_MAX = IW'((1 << (SW-1)) - 1);

    logic [N_ELEM-1:0]    svd;
    logic [N_ELEM*SW-1:0] smd [MAX_ORDER];
    logic [N_ELEM*SW-1:0] sm  [MAX_ORDER];
    logic [2:0]           ord_q;
    logic [2:0]           ord_next;
    stage_vec_t           sat_ev;
    logic [OW-1:0]        acc;

    assign ord_next = clamp_order(order_sel, MAX_ORDER);
    assign SD       = svd;

    for (genvar g = 0; g < MAX_ORDER; g++) begin : g_stage
        logic signed [IW-1:0] se [N_ELEM];
        logic [N_ELEM*IW-1:0] se_bus;
        logic signed [IW-1:0] su;
        logic signed [IW-1:0] raw;
        logic [N_ELEM*SW-1:0] sm_prev;
        logic [N_ELEM*SW-1:0] sm_l;
        logic                 active;
        logic                 ev;

        if (g == 0) begin : g_first
            assign sm_prev = '0;
        end else begin : g_chain
            assign sm_prev = sm[g-1];
        end

        assign active = (int'(ord_q) > g);

        always_comb begin
            se_bus = '0;
            for (int i = 0; i < N_ELEM; i++) begin
                se[i] = IW'(smd[g][i*SW +: SW]) + IW'(sm_prev[i*SW +: SW]) - IW'(svd[i]);
                se_bus[i*IW +: IW] = se[i];
            end
        end

        mis_min_tree #(.N(N_ELEM), .W(IW)) u_min (
            .din  (se_bus),
            .dmin (su)
        );

        // Normalise against the minimum, then clamp; inactive stages read as zero.
        always_comb begin
            sm_l = '0;
            ev   = 1'b0;
            raw  = '0;
            for (int i = 0; i < N_ELEM; i++) begin
                raw = se[i] - su;
                if (active) begin
                    if (raw > SAT_MAX) begin
                        sm_l[i*SW +: SW] = SW'(SAT_MAX);
                        ev = 1'b1;
                    end else begin
                        sm_l[i*SW +: SW] = SW'(raw);
                    end
                end
            end
        end

        assign sm[g]     = sm_l;
        assign sat_ev[g] = ev;
    end

    for (genvar g = MAX_ORDER; g < MAX_ORDER_LIMIT; g++) begin : g_unbuilt
        assign sat_ev[g] = 1'b0;
    end

    always_comb begin
        SFM = '0;
        acc = '0;
        for (int i = 0; i < N_ELEM; i++) begin
            acc = '0;
            for (int k = 0; k < MAX_ORDER; k++)
                acc = acc + OW'(sm[k][i*SW +: SW]);
            SFM[i*OW +: OW] = acc;
        end
    end

    // Stages beyond the newly selected order load zero, so a reduction flushes them at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            svd      <= '0;
            ord_q    <= 3'd1;
            sat_flag <= 1'b0;
            for (int k = 0; k < MAX_ORDER; k++)
                smd[k] <= '0;
        end else begin
            if (clk_en) begin
                svd   <= SV;
                ord_q <= ord_next;
                for (int k = 0; k < MAX_ORDER; k++)
                    smd[k] <= (k < int'(ord_next)) ? sm[k] : '0;
            end
            if (clk_en && (|sat_ev))
                sat_flag <= 1'b1;
            else if (sat_clr)
                sat_flag <= 1'b0;
        end
    end
endmodule

// File: tb/tb_mis_shaping_lf_nth.sv
// Directed bench for mis_shaping_lf_nth with an integer reference model of the filter.
`timescale 1ns/1ps
module tb_mis_shaping_lf_nth;
    localparam int N      = 4;
    localparam int MO     = 3;
    localparam int SW     = 7;
    localparam int OW     = SW + 1;
    localparam int SATMAX = (1 << (SW-1)) - 1;

    logic            clk = 1'b0;
    logic            rst;
    logic            clk_en;
    logic [2:0]      order_sel;
    logic            sat_clr;
    logic [N-1:0]    SV;
    logic [N-1:0]    SD;
    logic [N*OW-1:0] SFM;
    logic            sat_flag;

    int total = 0;
    int bad   = 0;
    bit chk_on = 1'b0;

    // Reference model state
    int m_svd [N];
    int m_smd [MO][N];
    int m_sm  [MO][N];
    int exp_sfm [N];
    int m_ord;
    bit m_sat;
    bit m_ev;

    mis_shaping_lf_nth #(.N_ELEM(N), .MAX_ORDER(MO), .SW(SW)) dut (
        .clk       (clk),
        .rst       (rst),
        .clk_en    (clk_en),
        .order_sel (order_sel),
        .sat_clr   (sat_clr),
        .SV        (SV),
        .SD        (SD),
        .SFM       (SFM),
        .sat_flag  (sat_flag)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int sfm_el(input int i);
        return int'(SFM[i*OW +: OW]);
    endfunction

    function automatic int clamp_ord(input int o);
        if (o < 1) return 1;
        if (o > MO) return MO;
        return o;
    endfunction

    // Outputs as a function of the model's registered state.
    task automatic model_eval();
        int se [N];
        int mn;
        int raw;
        m_ev = 1'b0;
        for (int k = 0; k < MO; k++)
            for (int i = 0; i < N; i++)
                m_sm[k][i] = 0;
        for (int k = 0; k < m_ord; k++) begin
            for (int i = 0; i < N; i++)
                se[i] = m_smd[k][i] - m_svd[i] + ((k > 0) ? m_sm[k-1][i] : 0);
            mn = se[0];
            for (int i = 1; i < N; i++)
                if (se[i] < mn) mn = se[i];
            for (int i = 0; i < N; i++) begin
                raw = se[i] - mn;
                if (raw > SATMAX) begin
                    raw  = SATMAX;
                    m_ev = 1'b1;
                end
                m_sm[k][i] = raw;
            end
        end
        for (int i = 0; i < N; i++) begin
            exp_sfm[i] = 0;
            for (int k = 0; k < MO; k++)
                exp_sfm[i] += m_sm[k][i];
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) m_svd[i] = 0;
        for (int k = 0; k < MO; k++)
            for (int i = 0; i < N; i++)
                m_smd[k][i] = 0;
        m_ord = 1;
        m_sat = 1'b0;
        model_eval();
    endtask

    task automatic model_edge(input bit en, input int osel, input bit clr, input logic [N-1:0] sv);
        int nord;
        if (en) begin
            nord = clamp_ord(osel);
            if (m_ev) m_sat = 1'b1;
            else if (clr) m_sat = 1'b0;
            for (int k = 0; k < MO; k++)
                for (int i = 0; i < N; i++)
                    m_smd[k][i] = (k < nord) ? m_sm[k][i] : 0;
            for (int i = 0; i < N; i++) m_svd[i] = int'(sv[i]);
            m_ord = nord;
        end else if (clr) begin
            m_sat = 1'b0;
        end
        model_eval();
    endtask

    task automatic step(input bit en, input int osel, input bit clr, input logic [N-1:0] sv);
        clk_en    = en;
        order_sel = 3'(osel);
        sat_clr   = clr;
        SV        = sv;
        @(posedge clk);
        model_edge(en, osel, clr, sv);
        #1;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        model_reset();
        #1;
        check("rst_sd", int'(SD), 0);
        check("rst_sfm1", sfm_el(1), 0);
        check("rst_sat", int'(sat_flag), 0);
        rst = 1'b0;
    endtask

    // Single compare process against the model on every falling edge.
    always @(negedge clk) begin
        if (chk_on) begin
            int exp_sd;
            exp_sd = 0;
            for (int i = 0; i < N; i++) exp_sd |= (m_svd[i] << i);
            check("cmp_sd", int'(SD), exp_sd);
            for (int i = 0; i < N; i++) check("cmp_sfm", sfm_el(i), exp_sfm[i]);
            check("cmp_sat", int'(sat_flag), int'(m_sat));
        end
    end

    logic [N-1:0] gtab [10] = '{4'd3, 4'd5, 4'd6, 4'd9, 4'd12, 4'd10, 4'd1, 4'd15, 4'd4, 4'd8};

    initial begin
        rst = 1'b1; clk_en = 1'b0; order_sel = 3'd1; sat_clr = 1'b0; SV = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("init_sd", int'(SD), 0);
        check("init_sfm0", sfm_el(0), 0);
        check("init_sat", int'(sat_flag), 0);
        rst = 1'b0;
        chk_on = 1'b1;

        // Order 1, one enabled edge
        step(1, 1, 0, 4'b0001);
        check("o1_sd", int'(SD), 1);
        check("o1_e0", sfm_el(0), 0);
        for (int i = 1; i < N; i++) check("o1_e", sfm_el(i), 1);
        step(0, 1, 0, 4'b1010);
        check("o1_hold_sd", int'(SD), 1);
        check("o1_hold_e1", sfm_el(1), 1);

        // Order 2, one enabled edge from reset
        apply_reset();
        step(1, 2, 0, 4'b0001);
        check("o2_e0", sfm_el(0), 0);
        for (int i = 1; i < N; i++) check("o2_e", sfm_el(i), 3);
        step(1, 2, 0, 4'b0110);

        // Reset with non-zero state, then idle with clk_en low
        apply_reset();
        step(0, 2, 0, 4'b1111);
        step(0, 3, 0, 4'b0101);
        check("rst_idle_sd", int'(SD), 0);
        check("rst_idle_e2", sfm_el(2), 0);

        // Saturation ramp at order 1
        apply_reset();
        for (int k = 1; k <= 64; k++) begin
            step(1, 1, 0, 4'b0001);
            if (k == 1 || k == 10 || k == 63 || k == 64)
                check("sat_ramp", sfm_el(2), (k == 64) ? 63 : k);
        end
        check("sat_pre", int'(sat_flag), 0);
        step(1, 1, 0, 4'b0001);
        check("sat_set", int'(sat_flag), 1);
        check("sat_hold_e1", sfm_el(1), 63);
        step(0, 1, 1, 4'b0001);
        check("sat_clr", int'(sat_flag), 0);
        step(1, 1, 1, 4'b0001);
        check("sat_set_wins", int'(sat_flag), 1);

        // Enable gating with SV changing every cycle
        apply_reset();
        for (int i = 0; i < 10; i++) begin
            step((i % 2) == 0, 2, 0, gtab[i]);
            check("gate_sd", int'(SD), int'(gtab[i - (i % 2)]));
        end

        // Order switching
        apply_reset();
        repeat (3) step(1, 2, 0, 4'b0001);
        check("osw_o2", sfm_el(1), 12);
        step(1, 1, 0, 4'b0001);
        check("osw_to1", sfm_el(1), 4);
        step(1, 7, 0, 4'b0001);
        check("osw_sel7", sfm_el(1), 18);
        check("osw_sel7_e0", sfm_el(0), 0);
        step(1, 0, 0, 4'b0001);
        check("osw_sel0", sfm_el(3), 6);
        step(0, 2, 0, 4'b0000);

        chk_on = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
